// File: rtl/transport_ctrl_if.sv
// Transport controller bundle: button/level inputs, sample tick, memory strobes and status outputs.
interface transport_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int MAG_W  = 4
);
    logic              codec_ready;
    logic              btn_play;
    logic              btn_stop;
    logic              btn_fast;
    logic              btn_slow;
    logic              mode;
    logic              loop_en;
    logic              sample_tick;
    logic [2:0]        state;
    logic              speed_up;
    logic [MAG_W-1:0]  speed_mag;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [MAG_W-1:0]  slow_phase;
    logic [ADDR_W:0]   rec_len;
    logic              at_end;

    modport master (
        output codec_ready, btn_play, btn_stop, btn_fast, btn_slow, mode, loop_en, sample_tick,
        input  state, speed_up, speed_mag, mem_req, mem_we, mem_addr, slow_phase, rec_len, at_end
    );

    modport slave (
        input  codec_ready, btn_play, btn_stop, btn_fast, btn_slow, mode, loop_en, sample_tick,
        output state, speed_up, speed_mag, mem_req, mem_we, mem_addr, slow_phase, rec_len, at_end
    );
endinterface

// File: rtl/transport_ctrl.sv
// Record/playback transport FSM with variable speed, sample address engine,
// loop playback and recorded-length tracking.
module transport_ctrl #(
    parameter int ADDR_W     = 20,
    parameter int MAX_FACTOR = 8,
    parameter int MAG_W      = $clog2(MAX_FACTOR + 1)
) (
    input  logic            clk,
    input  logic            rst,
    transport_ctrl_if.slave tif
);
    typedef enum logic [2:0] {
        INIT       = 3'b101,
        PLAY_STOP  = 3'b000,
        PLAY_PLAY  = 3'b010,
        PLAY_PAUSE = 3'b011,
        REC_STOP   = 3'b100,
        REC_REC    = 3'b110,
        REC_PAUSE  = 3'b111
    } state_t;

    localparam logic [MAG_W-1:0]  MAG_ONE   = MAG_W'(1);
    localparam logic [MAG_W-1:0]  MAG_TWO   = MAG_W'(2);
    localparam logic [MAG_W-1:0]  MAG_MAX   = MAG_W'(MAX_FACTOR);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic              mode_q;
    logic              speed_up_q, speed_up_d;
    logic [MAG_W-1:0]  speed_mag_q, speed_mag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MAG_W-1:0]  slow_phase_q, slow_phase_d;
    logic [ADDR_W:0]   rec_len_q, rec_len_d;
    logic              at_end_q, at_end_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              mode_chg;
    logic              advance;
    logic [ADDR_W:0]   addr_next;

    assign mode_chg = (mode_q != state_q[2]);

    always_comb begin
        state_d      = state_q;
        speed_up_d   = speed_up_q;
        speed_mag_d  = speed_mag_q;
        addr_d       = addr_q;
        slow_phase_d = slow_phase_q;
        rec_len_d    = rec_len_q;
        at_end_d     = at_end_q;
        mem_req_d    = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        advance      = 1'b0;
        addr_next    = {1'b0, addr_q};

        case (state_q)
            INIT: begin
                if (tif.codec_ready) state_d = state_t'({mode_q, 2'b00});
            end
            PLAY_STOP, REC_STOP: begin
                if (mode_chg) begin
                    state_d = state_t'({mode_q, 2'b00});
                end else if (tif.btn_play) begin
                    if (state_q == REC_STOP) begin
                        state_d   = REC_REC;
                        rec_len_d = '0;
                    end else if (rec_len_q != '0) begin
                        state_d = PLAY_PLAY;
                    end
                end
            end
            PLAY_PLAY, REC_REC: begin
                if (tif.btn_stop) begin
                    state_d = state_t'({state_q[2], 2'b00});
                end else begin
                    if (tif.sample_tick) begin
                        if (state_q == REC_REC) begin
                            mem_req_d  = 1'b1;
                            mem_we_d   = 1'b1;
                            mem_addr_d = addr_q;
                            addr_d     = addr_q + ADDR_ONE;
                            rec_len_d  = {1'b0, addr_q} + LEN_ONE;
                            if (addr_q == ADDR_LAST) begin
                                at_end_d = 1'b1;
                                state_d  = REC_STOP;
                            end
                        end else begin
                            if (speed_up_q) begin
                                mem_req_d  = 1'b1;
                                mem_we_d   = 1'b0;
                                mem_addr_d = addr_q;
                                advance    = 1'b1;
                                addr_next  = {1'b0, addr_q} + (ADDR_W + 1)'(speed_mag_q);
                            end else begin
                                if (slow_phase_q == '0) begin
                                    mem_req_d  = 1'b1;
                                    mem_we_d   = 1'b0;
                                    mem_addr_d = addr_q;
                                end
                                if (slow_phase_q == speed_mag_q - MAG_ONE) begin
                                    slow_phase_d = '0;
                                    advance      = 1'b1;
                                    addr_next    = {1'b0, addr_q} + LEN_ONE;
                                end else begin
                                    slow_phase_d = slow_phase_q + MAG_ONE;
                                end
                            end
                            // Never step onto or past the recorded length.
                            if (advance) begin
                                if (addr_next >= rec_len_q) begin
                                    if (tif.loop_en) begin
                                        addr_d = '0;
                                    end else begin
                                        at_end_d = 1'b1;
                                        state_d  = PLAY_STOP;
                                    end
                                end else begin
                                    addr_d = addr_next[ADDR_W-1:0];
                                end
                            end
                        end
                    end
                    if (tif.btn_play && state_d == state_q) state_d = state_t'({state_q[2], 2'b11});
                end
            end
            PLAY_PAUSE, REC_PAUSE: begin
                if (mode_chg)          state_d = state_t'({mode_q, 2'b00});
                else if (tif.btn_stop) state_d = state_t'({state_q[2], 2'b00});
                else if (tif.btn_play) state_d = state_t'({state_q[2], 2'b10});
            end
            default: state_d = INIT;
        endcase

        if (tif.btn_fast && !tif.btn_slow) begin
            if (speed_up_q) begin
                if (speed_mag_q < MAG_MAX) speed_mag_d = speed_mag_q + MAG_ONE;
            end else if (speed_mag_q == MAG_ONE) begin
                speed_up_d  = 1'b1;
                speed_mag_d = MAG_TWO;
            end else begin
                speed_mag_d = speed_mag_q - MAG_ONE;
            end
        end else if (tif.btn_slow && !tif.btn_fast) begin
            if (!speed_up_q) begin
                if (speed_mag_q < MAG_MAX) speed_mag_d = speed_mag_q + MAG_ONE;
            end else if (speed_mag_q == MAG_TWO) begin
                speed_up_d  = 1'b0;
                speed_mag_d = MAG_ONE;
            end else begin
                speed_mag_d = speed_mag_q - MAG_ONE;
            end
        end

        // Recording and init always run at x1.
        if (state_d[2]) begin
            speed_up_d  = 1'b0;
            speed_mag_d = MAG_ONE;
        end
        if ({speed_up_d, speed_mag_d} != {speed_up_q, speed_mag_q}) slow_phase_d = '0;

        if (state_d[1:0] == 2'b00) begin
            addr_d       = '0;
            slow_phase_d = '0;
        end
        if (state_d[1:0] == 2'b10 && state_q[1:0] != 2'b10) at_end_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            mode_q       <= 1'b1;
            speed_up_q   <= 1'b0;
            speed_mag_q  <= MAG_ONE;
            addr_q       <= '0;
            slow_phase_q <= '0;
            rec_len_q    <= '0;
            at_end_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= tif.mode;
            speed_up_q   <= speed_up_d;
            speed_mag_q  <= speed_mag_d;
            addr_q       <= addr_d;
            slow_phase_q <= slow_phase_d;
            rec_len_q    <= rec_len_d;
            at_end_q     <= at_end_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign tif.state      = state_q;
    assign tif.speed_up   = speed_up_q;
    assign tif.speed_mag  = speed_mag_q;
    assign tif.mem_req    = mem_req_q;
    assign tif.mem_we     = mem_we_q;
    assign tif.mem_addr   = mem_addr_q;
    assign tif.slow_phase = slow_phase_q;
    assign tif.rec_len    = rec_len_q;
    assign tif.at_end     = at_end_q;
endmodule

// File: tb/tb_transport_ctrl.sv
// Bench for transport_ctrl: vector table, directed corner sequences, then random
// stimulus checked against a behavioural transport model.
module tb_transport_ctrl;
    localparam int AW    = 4;
    localparam int MAXF  = 8;
    localparam int MW    = $clog2(MAXF + 1);
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    transport_ctrl_if #(.ADDR_W(AW), .MAG_W(MW)) tif();
    transport_ctrl #(.ADDR_W(AW), .MAX_FACTOR(MAXF)) dut (.clk(clk), .rst(rst), .tif(tif));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit cr, md, lp, pl, st, fa, sl, tk;
        int e_st; bit e_rq, e_we; int e_ad, e_len; bit e_end, e_up; int e_mag, e_ph;
    } vec_t;
    vec_t tbl[$];

    // behavioural model state
    bit model_on = 1'b0;
    int m_st, m_addr, m_len, m_ph, m_mag, m_maddr;
    bit m_up, m_end, m_mode_s, m_req, m_we;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 5; m_addr = 0; m_len = 0; m_ph = 0; m_mag = 1; m_maddr = 0;
        m_up = 0; m_end = 0; m_mode_s = 1; m_req = 0; m_we = 0;
    endtask

    function automatic bit is_run(input int s);
        return (s == 2 || s == 6);
    endfunction

    task automatic model_step();
        int ns, step, old_mag;
        bit old_up, rec_side;
        ns = m_st;
        m_req = 0;
        old_up = m_up; old_mag = m_mag;
        rec_side = (m_st >= 4);
        if (m_st == 5) begin
            if (tif.codec_ready) ns = m_mode_s ? 4 : 0;
        end else if (m_st == 0 || m_st == 4) begin
            if (m_mode_s != rec_side) ns = m_mode_s ? 4 : 0;
            else if (tif.btn_play) begin
                if (m_st == 4) begin ns = 6; m_len = 0; end
                else if (m_len > 0) ns = 2;
            end
        end else if (is_run(m_st)) begin
            if (tif.btn_stop) ns = m_st - 2;
            else begin
                if (tif.sample_tick) begin
                    m_req = 1; m_maddr = m_addr;
                    if (m_st == 6) begin
                        m_we = 1;
                        m_addr++;
                        m_len = m_addr;
                        if (m_addr == DEPTH) begin m_end = 1; ns = 4; end
                    end else begin
                        m_we = 0;
                        if (m_up) step = m_mag;
                        else begin
                            m_req = (m_ph == 0);
                            step  = (m_ph == m_mag - 1) ? 1 : 0;
                            m_ph  = (m_ph + 1) % m_mag;
                        end
                        if (step > 0) begin
                            if (m_addr + step >= m_len) begin
                                if (tif.loop_en) m_addr = 0;
                                else begin m_end = 1; ns = 0; end
                            end else m_addr = m_addr + step;
                        end
                    end
                end
                if (tif.btn_play && ns == m_st) ns = m_st + 1;
            end
        end else begin
            if (m_mode_s != rec_side) ns = m_mode_s ? 4 : 0;
            else if (tif.btn_stop) ns = m_st - 3;
            else if (tif.btn_play) ns = m_st - 1;
        end
        if (tif.btn_fast && !tif.btn_slow) begin
            if (m_up) m_mag = (m_mag < MAXF) ? m_mag + 1 : m_mag;
            else if (m_mag == 1) begin m_up = 1; m_mag = 2; end
            else m_mag = m_mag - 1;
        end else if (tif.btn_slow && !tif.btn_fast) begin
            if (!m_up) m_mag = (m_mag < MAXF) ? m_mag + 1 : m_mag;
            else if (m_mag == 2) begin m_up = 0; m_mag = 1; end
            else m_mag = m_mag - 1;
        end
        if (ns >= 4) begin m_up = 0; m_mag = 1; end
        if (m_up != old_up || m_mag != old_mag) m_ph = 0;
        if (ns == 0 || ns == 4) begin m_addr = 0; m_ph = 0; end
        if (is_run(ns) && !is_run(m_st)) m_end = 0;
        m_st = ns;
        m_mode_s = tif.mode;
    endtask

    task automatic cyc(input bit pl, input bit st, input bit fa, input bit sl, input bit tk);
        tif.btn_play = pl; tif.btn_stop = st; tif.btn_fast = fa; tif.btn_slow = sl;
        tif.sample_tick = tk;
        if (model_on) model_step();
        @(posedge clk); #1;
        tif.btn_play = 0; tif.btn_stop = 0; tif.btn_fast = 0; tif.btn_slow = 0;
        tif.sample_tick = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        int sp_exp[6];
        bit rq_exp[6];
        int ad_exp[6];
        int lp_exp[5];

        tif.codec_ready = 0; tif.mode = 0; tif.loop_en = 0;
        tif.btn_play = 0; tif.btn_stop = 0; tif.btn_fast = 0; tif.btn_slow = 0;
        tif.sample_tick = 0;

        //            cr md lp pl st fa sl tk  st rq we ad len en up mag ph
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0, 0,  6, 0, 0, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1,  6, 1, 1, 0, 1, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1,  6, 1, 1, 1, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0,  6, 0, 0, 0, 2, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1,  6, 1, 1, 2, 3, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1,  6, 1, 1, 3, 4, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 1,  6, 1, 1, 4, 5, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 0, 0,  4, 0, 0, 0, 5, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  4, 0, 0, 0, 5, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 5, 0, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 0, 0, 0,  2, 0, 0, 0, 5, 0, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 0, 5, 0, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  2, 1, 0, 2, 5, 0, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 4, 5, 1, 1, 2, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 5, 1, 1, 2, 0});

        #2 rst = 0;
        #1;
        chk("reset_state", tif.state, 5);
        chk("reset_speed_up", tif.speed_up, 0);
        chk("reset_speed_mag", tif.speed_mag, 1);
        chk("reset_mem_req", tif.mem_req, 0);
        chk("reset_mem_we", tif.mem_we, 0);
        chk("reset_mem_addr", tif.mem_addr, 0);
        chk("reset_rec_len", tif.rec_len, 0);
        chk("reset_slow_phase", tif.slow_phase, 0);
        chk("reset_at_end", tif.at_end, 0);
        @(posedge clk); #1;
        rst = 1;

        foreach (tbl[i]) begin
            tif.codec_ready = tbl[i].cr; tif.mode = tbl[i].md; tif.loop_en = tbl[i].lp;
            cyc(tbl[i].pl, tbl[i].st, tbl[i].fa, tbl[i].sl, tbl[i].tk);
            chk($sformatf("vec%0d_state", i), tif.state, tbl[i].e_st);
            chk($sformatf("vec%0d_mem_req", i), tif.mem_req, tbl[i].e_rq);
            if (tbl[i].e_rq) begin
                chk($sformatf("vec%0d_mem_we", i), tif.mem_we, tbl[i].e_we);
                chk($sformatf("vec%0d_mem_addr", i), tif.mem_addr, tbl[i].e_ad);
            end
            chk($sformatf("vec%0d_rec_len", i), tif.rec_len, tbl[i].e_len);
            chk($sformatf("vec%0d_at_end", i), tif.at_end, tbl[i].e_end);
            chk($sformatf("vec%0d_speed_up", i), tif.speed_up, tbl[i].e_up);
            chk($sformatf("vec%0d_speed_mag", i), tif.speed_mag, tbl[i].e_mag);
            chk($sformatf("vec%0d_slow_phase", i), tif.slow_phase, tbl[i].e_ph);
        end

        // record 2 samples, with stop and tick colliding at the end
        tif.mode = 1; idle(2);
        chk("rec_stop_state", tif.state, 4);
        chk("rec_forces_x1_up", tif.speed_up, 0);
        chk("rec_forces_x1_mag", tif.speed_mag, 1);
        cyc(1, 0, 0, 0, 0);
        chk("rec_entry_clears_at_end", tif.at_end, 0);
        chk("rec_entry_clears_len", tif.rec_len, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        chk("rec2_addr", tif.mem_addr, 1);
        cyc(0, 1, 0, 0, 1);
        chk("stop_tick_no_req", tif.mem_req, 0);
        chk("stop_tick_state", tif.state, 4);
        chk("stop_tick_len", tif.rec_len, 2);

        // slow x1/3 playback of 2 samples
        tif.mode = 0; idle(2);
        cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        chk("slow3_up", tif.speed_up, 0);
        chk("slow3_mag", tif.speed_mag, 3);
        cyc(1, 0, 0, 0, 0);
        sp_exp = '{0, 1, 2, 0, 1, 2};
        rq_exp = '{1, 0, 0, 1, 0, 0};
        ad_exp = '{0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("slow_phase%0d", i), tif.slow_phase, sp_exp[i]);
            cyc(0, 0, 0, 0, 1);
            chk($sformatf("slow_req%0d", i), tif.mem_req, rq_exp[i]);
            if (rq_exp[i]) chk($sformatf("slow_addr%0d", i), tif.mem_addr, ad_exp[i]);
            idle(1);
        end
        chk("slow_end_state", tif.state, 0);
        chk("slow_end_at_end", tif.at_end, 1);

        // speed saturation and simultaneous fast/slow
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 1, 0, 0);
        chk("back_to_x1_up", tif.speed_up, 0);
        chk("back_to_x1_mag", tif.speed_mag, 1);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0);
        chk("sat_up", tif.speed_up, 1);
        chk("sat_mag", tif.speed_mag, MAXF);
        cyc(0, 0, 0, 1, 0);
        chk("sat_slow_mag", tif.speed_mag, MAXF - 1);
        cyc(0, 0, 1, 1, 0);
        chk("both_btn_mag", tif.speed_mag, MAXF - 1);
        chk("both_btn_up", tif.speed_up, 1);

        // loop playback with pause and mode flip in pause
        tif.mode = 1; idle(2);
        chk("loop_prep_mag", tif.speed_mag, 1);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        chk("loop_len", tif.rec_len, 3);
        tif.mode = 0; tif.loop_en = 1; idle(2);
        cyc(1, 0, 0, 0, 0);
        lp_exp = '{0, 1, 2, 0, 1};
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk($sformatf("loop_req%0d", i), tif.mem_req, 1);
            chk($sformatf("loop_addr%0d", i), tif.mem_addr, lp_exp[i]);
            chk($sformatf("loop_state%0d", i), tif.state, 2);
        end
        cyc(1, 0, 0, 0, 0);
        chk("pause_state", tif.state, 3);
        cyc(0, 0, 0, 0, 1);
        chk("pause_no_req", tif.mem_req, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("pause_holds_addr", tif.mem_addr, 2);
        cyc(1, 0, 0, 0, 0);
        tif.mode = 1; idle(2);
        chk("pause_mode_flip", tif.state, 4);

        // fill memory to the last address
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 1);
            if (i == 0 || i == DEPTH - 1) chk($sformatf("full_addr%0d", i), tif.mem_addr, i);
        end
        chk("full_len", tif.rec_len, DEPTH);
        chk("full_at_end", tif.at_end, 1);
        chk("full_state", tif.state, 4);
        chk("full_req", tif.mem_req, 1);

        // async reset mid-recording
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        #2 rst = 0;
        #1;
        chk("async_rst_state", tif.state, 5);
        chk("async_rst_len", tif.rec_len, 0);
        chk("async_rst_req", tif.mem_req, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        model_on = 1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) tif.mode = ~tif.mode;
            if ($urandom_range(99) == 0) tif.loop_en = ~tif.loop_en;
            cyc($urandom_range(15) == 0, $urandom_range(39) == 0, $urandom_range(11) == 0,
                $urandom_range(11) == 0, $urandom_range(2) == 0);
            chk("rand_state", tif.state, m_st);
            chk("rand_mem_req", tif.mem_req, m_req);
            if (m_req) begin
                chk("rand_mem_we", tif.mem_we, m_we);
                chk("rand_mem_addr", tif.mem_addr, m_maddr);
            end
            chk("rand_rec_len", tif.rec_len, m_len);
            chk("rand_at_end", tif.at_end, m_end);
            chk("rand_speed_up", tif.speed_up, m_up);
            chk("rand_speed_mag", tif.speed_mag, m_mag);
            chk("rand_slow_phase", tif.slow_phase, m_ph);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
